// File: rtl/aes_sb_pkg.sv
// Shared types and helpers for the multi-channel AES result scoreboard.
package aes_sb_pkg;

    localparam int AES_BLK_W = 128;
    // Counter arithmetic is done at this width, then truncated to CNT_W.
    localparam int SAT_W     = 64;

    // LSB position of channel ch in a flat bus of w-bit words.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

    // a + b clamped to max; the extra sum bit keeps the carry visible.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input logic [SAT_W-1:0] max);
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max}) begin
            return max;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/sb_exp_fifo.sv
// Expected-value FIFO for one scoreboard channel. Pointers carry an extra
// MSB so full and empty are distinguishable at occupancy DEPTH and 0.
// A push while full is accepted only when a pop happens in the same cycle.
module sb_exp_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              wr_en;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers; clear empties the FIFO and overrides any traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_en    = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && (!full || pop)) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/aes_scoreboard_mc.sv
// Multi-channel in-order scoreboard: one expected FIFO per channel, chip
// results compared against the FIFO head, saturating global counters.
// Optional first-mismatch capture enabled by defining SB_ERR_LOG_EN.
module aes_scoreboard_mc
    import aes_sb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = AES_BLK_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32,
    localparam int ERR_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        exp_vld,
    input  logic [NUM_CH*DATA_W-1:0] exp_data,
    input  logic [NUM_CH-1:0]        chip_vld,
    input  logic [NUM_CH*DATA_W-1:0] chip_data,
    output logic [CNT_W-1:0]         total,
    output logic [CNT_W-1:0]         correct,
    output logic [CNT_W-1:0]         orphan,
    output logic [NUM_CH-1:0]        ovf,
    output logic                     mismatch,
    output logic                     idle
`ifdef SB_ERR_LOG_EN
    ,
    output logic [ERR_CH_W-1:0]      err_ch,
    output logic [DATA_W-1:0]        err_exp,
    output logic [DATA_W-1:0]        err_act,
    output logic                     err_vld
`endif
);
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    logic [NUM_CH-1:0]             push, pop, cmp, hit, orph;
    logic [NUM_CH-1:0]             fifo_full, fifo_empty;
    logic [NUM_CH-1:0][DATA_W-1:0] fifo_dout;
    logic [NUM_CH-1:0][DATA_W-1:0] act;
    logic [SAT_W-1:0]              n_cmp, n_hit, n_orph;

    logic [CNT_W-1:0]  total_q, total_d, correct_q, correct_d, orphan_q, orphan_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              mismatch_q, mismatch_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sb_exp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (exp_data[ch_lsb(c, DATA_W) +: DATA_W]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c]),
            .dout  (fifo_dout[c])
        );
    end

    // Per-channel push/pop/compare decisions and their population counts.
    // A push into an empty FIFO is not visible to a same-cycle chip result.
    always_comb begin
        n_cmp  = '0;
        n_hit  = '0;
        n_orph = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            act[c]  = chip_data[ch_lsb(c, DATA_W) +: DATA_W];
            push[c] = exp_vld[c] & ~clr;
            pop[c]  = chip_vld[c] & ~fifo_empty[c] & ~clr;
            cmp[c]  = pop[c];
            hit[c]  = pop[c] && (fifo_dout[c] == act[c]);
            orph[c] = chip_vld[c] & fifo_empty[c] & ~clr;
            n_cmp   = n_cmp  + SAT_W'(cmp[c]);
            n_hit   = n_hit  + SAT_W'(hit[c]);
            n_orph  = n_orph + SAT_W'(orph[c]);
        end
    end

    // Next counter and sticky-flag values; clear takes priority.
    always_comb begin
        total_d    = CNT_W'(sat_add(SAT_W'(total_q),   n_cmp,  CNT_MAX));
        correct_d  = CNT_W'(sat_add(SAT_W'(correct_q), n_hit,  CNT_MAX));
        orphan_d   = CNT_W'(sat_add(SAT_W'(orphan_q),  n_orph, CNT_MAX));
        ovf_d      = ovf_q | (exp_vld & fifo_full & ~pop);
        mismatch_d = mismatch_q | (|(cmp & ~hit));
        if (clr) begin
            total_d    = '0;
            correct_d  = '0;
            orphan_d   = '0;
            ovf_d      = '0;
            mismatch_d = 1'b0;
        end
    end

    // Counter and sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q    <= '0;
            correct_q  <= '0;
            orphan_q   <= '0;
            ovf_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            total_q    <= total_d;
            correct_q  <= correct_d;
            orphan_q   <= orphan_d;
            ovf_q      <= ovf_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign total    = total_q;
    assign correct  = correct_q;
    assign orphan   = orphan_q;
    assign ovf      = ovf_q;
    assign mismatch = mismatch_q;
    assign idle     = &fifo_empty;

`ifdef SB_ERR_LOG_EN
    logic [ERR_CH_W-1:0] err_ch_q, err_ch_d;
    logic [DATA_W-1:0]   err_exp_q, err_exp_d, err_act_q, err_act_d;
    logic                err_vld_q, err_vld_d;

    // Capture only the first failing compare; descending scan leaves the
    // lowest failing channel selected.
    always_comb begin
        err_ch_d  = err_ch_q;
        err_exp_d = err_exp_q;
        err_act_d = err_act_q;
        err_vld_d = err_vld_q;
        if (clr) begin
            err_ch_d  = '0;
            err_exp_d = '0;
            err_act_d = '0;
            err_vld_d = 1'b0;
        end else if (!err_vld_q) begin
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (cmp[c] && !hit[c]) begin
                    err_ch_d  = ERR_CH_W'(c);
                    err_exp_d = fifo_dout[c];
                    err_act_d = act[c];
                    err_vld_d = 1'b1;
                end
            end
        end
    end

    // Error log registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ch_q  <= '0;
            err_exp_q <= '0;
            err_act_q <= '0;
            err_vld_q <= 1'b0;
        end else begin
            err_ch_q  <= err_ch_d;
            err_exp_q <= err_exp_d;
            err_act_q <= err_act_d;
            err_vld_q <= err_vld_d;
        end
    end

    assign err_ch  = err_ch_q;
    assign err_exp = err_exp_q;
    assign err_act = err_act_q;
    assign err_vld = err_vld_q;
`endif

endmodule
